// File: rtl/conv_vector_narrow_pkg.sv
// Shared constants and code helpers for the 32-bit to OUT_W-bit narrowing path.
package conv_pkg;

    localparam int INT_W = 32;

    // Largest code for an M-bit result: {0,1..1} when signed, all-ones when unsigned.
    function automatic logic [INT_W-1:0] max_code(input int m, input logic sgn);
        logic [INT_W-1:0] r;
        r = '0;
        for (int i = 0; i < INT_W; i++) begin
            if ((i < m - 1) || (!sgn && (i == m - 1))) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Most negative M-bit signed code, {1,0..0}.
    function automatic logic [INT_W-1:0] min_code(input int m);
        logic [INT_W-1:0] r;
        r = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (i == m - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_vector_narrow_if.sv
// Stream bus of the narrowing block: 32-bit integer beats in, OUT_W-bit vectors out.
interface conv_vector_narrow_if
    import conv_pkg::*;
#(
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] in_data;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;

    // Producer of input beats and consumer of output beats.
    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // The narrowing block itself.
    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/conv_vector_narrow_range_check.sv
// Combinational range check of a 32-bit integer against the OUT_W-bit code space.
module conv_range_check
    import conv_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [INT_W-1:0] in_data_i,
    input  logic             in_signed_i,
    output logic             ovf_hi_o,
    output logic             ovf_lo_o
);
    localparam logic [INT_W-1:0] MAX_S = max_code(OUT_W, 1'b1);
    localparam logic [INT_W-1:0] MAX_U = max_code(OUT_W, 1'b0);
    localparam logic [INT_W-1:0] MIN_S = INT_W'(0) - min_code(OUT_W);

    // Signed beats compare two's-complement against [-2^(M-1), 2^(M-1)-1]; unsigned only against 2^M-1.
    always_comb begin
        ovf_hi_o = 1'b0;
        ovf_lo_o = 1'b0;
        if (in_signed_i) begin
            ovf_hi_o = $signed(in_data_i) > $signed(MAX_S);
            ovf_lo_o = $signed(in_data_i) < $signed(MIN_S);
        end else begin
            ovf_hi_o = in_data_i > MAX_U;
        end
    end
endmodule

// File: rtl/conv_vector_narrow.sv
// Two-stage valid/ready pipeline narrowing 32-bit integers to OUT_W-bit vectors,
// with saturate-or-wrap on overflow and sticky/counted overflow reporting.
module conv_vector_narrow
    import conv_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter bit SAT   = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    conv_vector_narrow_if.slave bus,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);
    localparam logic [OUT_W-1:0] SAT_MAX_S = OUT_W'(max_code(OUT_W, 1'b1));
    localparam logic [OUT_W-1:0] SAT_MAX_U = OUT_W'(max_code(OUT_W, 1'b0));
    localparam logic [OUT_W-1:0] SAT_MIN   = OUT_W'(min_code(OUT_W));

    logic             rc_hi;
    logic             rc_lo;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_acc;

    logic             s1_v_q, s1_v_d;
    logic [OUT_W-1:0] s1_low_q;
    logic             s1_sgn_q;
    logic             s1_hi_q;
    logic             s1_lo_q;

    logic [OUT_W-1:0] res;
    logic             s2_v_q, s2_v_d;
    logic [OUT_W-1:0] s2_data_q, s2_data_d;
    logic             s2_ovf_q, s2_ovf_d;

    logic             ovf_evt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    conv_range_check #(
        .OUT_W(OUT_W)
    ) u_range (
        .in_data_i  (bus.in_data),
        .in_signed_i(bus.in_signed),
        .ovf_hi_o   (rc_hi),
        .ovf_lo_o   (rc_lo)
    );

    // Handshake: each stage advances when it is empty or the stage after it advances.
    always_comb begin
        s2_adv = !s2_v_q || bus.out_ready;
        s1_adv = !s1_v_q || s2_adv;
        in_acc = bus.in_valid && s1_adv;
        s1_v_d = s1_adv ? bus.in_valid : s1_v_q;
        s2_v_d = s2_adv ? s1_v_q : s2_v_q;
    end

    // Result selection: saturate to the code-space limits or keep the low bits.
    always_comb begin
        res = s1_low_q;
        if (SAT && s1_hi_q) begin
            res = s1_sgn_q ? SAT_MAX_S : SAT_MAX_U;
        end else if (SAT && s1_lo_q) begin
            res = SAT_MIN;
        end
        s2_data_d = s2_data_q;
        s2_ovf_d  = s2_ovf_q;
        if (s2_adv && s1_v_q) begin
            s2_data_d = res;
            s2_ovf_d  = s1_hi_q | s1_lo_q;
        end
    end

    // Overflow bookkeeping; clr wins over a same-cycle overflow beat.
    always_comb begin
        ovf_evt  = s2_v_q && bus.out_ready && s2_ovf_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (ovf_evt) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage valids: a reset drops every in-flight beat immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
        end
    end

    // S1 payload: only the low OUT_W bits of the integer can reach the output, so only they are kept.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            s1_low_q <= bus.in_data[OUT_W-1:0];
            s1_sgn_q <= bus.in_signed;
            s1_hi_q  <= rc_hi;
            s1_lo_q  <= rc_lo;
        end
    end

    // S2 payload: held while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_data_q <= '0;
            s2_ovf_q  <= 1'b0;
        end else begin
            s2_data_q <= s2_data_d;
            s2_ovf_q  <= s2_ovf_d;
        end
    end

    // Overflow sticky flag and saturating event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_ovf   = s2_ovf_q;
    assign ovf_sticky    = sticky_q;
    assign ovf_count     = cnt_q;
endmodule

// File: tb/tb_conv_vector_narrow.sv
// Bench for conv_vector_narrow: three builds (saturate, wrap, 2-bit counter) share one stimulus
// stream and are scored against an arithmetic reference model.
module tb_conv_vector_narrow;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_ready;

    logic        stk_m, stk_w, stk_s;
    logic [15:0] cnt_m, cnt_w;
    logic [1:0]  cnt_s;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state
    logic [32:0] q[$];
    int          mdl_cnt;
    int          mdl_cnt_s;
    logic        mdl_stk;
    logic        hold;
    logic [W-1:0] held_m, held_w;
    logic        held_o;
    logic        last_acc;
    logic        last_rdy;
    logic        ov_at_neg;

    always #5 clk = ~clk;

    conv_vector_narrow_if #(.OUT_W(W)) bus_m ();
    conv_vector_narrow_if #(.OUT_W(W)) bus_w ();
    conv_vector_narrow_if #(.OUT_W(W)) bus_s ();

    assign bus_m.in_valid  = in_valid;
    assign bus_m.in_data   = in_data;
    assign bus_m.in_signed = in_signed;
    assign bus_m.out_ready = out_ready;
    assign bus_w.in_valid  = in_valid;
    assign bus_w.in_data   = in_data;
    assign bus_w.in_signed = in_signed;
    assign bus_w.out_ready = out_ready;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_data   = in_data;
    assign bus_s.in_signed = in_signed;
    assign bus_s.out_ready = out_ready;

    conv_vector_narrow #(.OUT_W(W), .SAT(1'b1), .CNT_W(16)) dut_m (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_m), .ovf_sticky(stk_m), .ovf_count(cnt_m));
    conv_vector_narrow #(.OUT_W(W), .SAT(1'b0), .CNT_W(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_w), .ovf_sticky(stk_w), .ovf_count(cnt_w));
    conv_vector_narrow #(.OUT_W(W), .SAT(1'b1), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_s), .ovf_sticky(stk_s), .ovf_count(cnt_s));

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    // Value-level narrowing: interpret, compare with the code-space bounds, then saturate or wrap.
    function automatic void ref_narrow(input logic [31:0] d, input logic sgn, input bit sat,
                                       output logic [W-1:0] r, output logic ovf);
        longint v, hi, lo;
        v  = sgn ? longint'($signed(d)) : longint'(d);
        hi = sgn ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
        lo = sgn ? -(longint'(1) << (W - 1)) : 0;
        ovf = (v > hi) || (v < lo);
        if (!sat || !ovf) r = d[W-1:0];
        else if (v > hi)  r = hi[W-1:0];
        else              r = lo[W-1:0];
    endfunction

    // One clock: check registered state, drive inputs at the falling edge, score the coming edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic s,
                         input logic ordy, input logic c);
        logic [32:0]  e;
        logic [W-1:0] er, ew;
        logic         eo, ewo;
        @(negedge clk);
        ov_at_neg = bus_m.out_valid;
        check_eq("cnt_m", cnt_m, 64'(mdl_cnt));
        check_eq("cnt_w", cnt_w, 64'(mdl_cnt));
        check_eq("cnt_s", cnt_s, 64'(mdl_cnt_s));
        check_eq("stk_m", stk_m, mdl_stk);
        check_eq("stk_s", stk_s, mdl_stk);
        if (hold) begin
            check_eq("hold_v", bus_m.out_valid, 1'b1);
            check_eq("hold_d", bus_m.out_data, held_m);
            check_eq("hold_o", bus_m.out_ovf, held_o);
            check_eq("hold_dw", bus_w.out_data, held_w);
        end
        in_valid  = v;
        in_data   = d;
        in_signed = s;
        out_ready = ordy;
        clr       = c;
        #1;
        last_rdy = bus_m.in_ready;
        last_acc = v && bus_m.in_ready;
        check_eq("ov_w_eq", bus_w.out_valid, bus_m.out_valid);
        check_eq("ov_s_eq", bus_s.out_valid, bus_m.out_valid);
        if (bus_m.out_valid && ordy) begin
            if (q.size() == 0) begin
                check_eq("spurious_beat", bus_m.out_valid, 1'b0);
            end else begin
                e = q.pop_front();
                ref_narrow(e[31:0], e[32], 1'b1, er, eo);
                ref_narrow(e[31:0], e[32], 1'b0, ew, ewo);
                check_eq("data_sat", bus_m.out_data, er);
                check_eq("ovf_sat", bus_m.out_ovf, eo);
                check_eq("data_s", bus_s.out_data, er);
                check_eq("data_wrap", bus_w.out_data, ew);
                check_eq("ovf_wrap", bus_w.out_ovf, ewo);
                if (eo && !c) begin
                    mdl_stk = 1'b1;
                    if (mdl_cnt < 65535) mdl_cnt++;
                    if (mdl_cnt_s < 3) mdl_cnt_s++;
                end
            end
        end
        if (c) begin
            mdl_cnt   = 0;
            mdl_cnt_s = 0;
            mdl_stk   = 1'b0;
        end
        if (last_acc) q.push_back({s, d});
        hold   = bus_m.out_valid && !ordy;
        held_m = bus_m.out_data;
        held_w = bus_w.out_data;
        held_o = bus_m.out_ovf;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] b[8];
        b = '{32'd127, 32'd128, 32'hFFFF_FF80, 32'hFFFF_FF7F, 32'd255, 32'd256, 32'd0, 32'hFFFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 600)) - 300);
            default: return b[$urandom_range(0, 7)];
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, acc5;
        logic [31:0] bp[4];
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
        mdl_cnt = 0; mdl_cnt_s = 0; mdl_stk = 1'b0; hold = 1'b0;
        held_m = '0; held_w = '0; held_o = 1'b0; last_acc = 1'b0; last_rdy = 1'b0; ov_at_neg = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check_eq("rst_out_valid", bus_m.out_valid, 1'b0);
        check_eq("rst_in_ready", bus_m.in_ready, 1'b1);
        check_eq("rst_out_data", bus_m.out_data, 8'h00);
        check_eq("rst_out_ovf", bus_m.out_ovf, 1'b0);
        check_eq("rst_count", cnt_m, 16'd0);
        check_eq("rst_sticky", stk_m, 1'b0);
        rst_n = 1'b1;

        // Range and saturation boundaries, signed and unsigned
        cycle(1, 32'd200, 1, 1, 0);
        cycle(1, -32'sd200, 1, 1, 0);
        cycle(1, 32'hFFFF_FFFF, 1, 1, 0);
        cycle(1, -32'sd128, 1, 1, 0);
        cycle(1, 32'd127, 1, 1, 0);
        cycle(1, 32'd255, 0, 1, 0);
        cycle(1, 32'd256, 0, 1, 0);
        cycle(1, 32'hFFFF_FFFF, 0, 1, 0);
        cycle(1, 32'd300, 1, 1, 0);
        cycle(1, -32'sd129, 1, 1, 0);
        repeat (3) cycle(0, 0, 0, 1, 0);

        // Backpressure: out_ready low for 5 clocks while offering 1..4
        bp = '{32'd1, 32'd2, 32'd3, 32'd4};
        idx = 0; acc5 = 0;
        for (int i = 0; i < 25 && idx < 4; i++) begin
            cycle(1, bp[idx], 0, (i >= 5), 0);
            if (last_acc) begin
                idx++;
                if (i < 5) acc5++;
            end
            if (i == 4) check_eq("bp_in_ready", last_rdy, 1'b0);
        end
        check_eq("bp_accepted", acc5, 2);
        check_eq("bp_all_sent", idx, 4);
        repeat (4) cycle(0, 0, 0, 1, 0);
        check_eq("bp_drained", q.size(), 0);

        // Counters: three overflow beats, then clr against the fourth
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 32'd1000, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        settle();
        check_eq("cnt_three", cnt_m, 16'd3);
        check_eq("sticky_set", stk_m, 1'b1);
        cycle(0, 0, 0, 1, 1);
        settle();
        check_eq("cnt_clr_wins", cnt_m, 16'd0);
        check_eq("sticky_clr_wins", stk_m, 1'b0);

        // Counter saturation in the 2-bit build
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cycle(1, 32'd500, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        settle();
        check_eq("cnt2_saturate", cnt_s, 2'd3);
        check_eq("cnt16_five", cnt_m, 16'd5);

        // Randomized traffic with random stalls and occasional clr
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_val(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end

        // Reset with two beats in flight
        cycle(1, 32'd900, 1, 0, 0);
        cycle(1, 32'd7, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid_m", bus_m.out_valid, 1'b0);
        check_eq("midrst_valid_w", bus_w.out_valid, 1'b0);
        check_eq("midrst_count", cnt_m, 16'd0);
        check_eq("midrst_sticky", stk_m, 1'b0);
        q.delete();
        mdl_cnt = 0; mdl_cnt_s = 0; mdl_stk = 1'b0; hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 32'd5, 0, 1, 0);
        check_eq("post_rst_acc", last_acc, 1'b1);
        cycle(0, 0, 0, 1, 0);
        check_eq("lat_one_clk", ov_at_neg, 1'b0);
        cycle(0, 0, 0, 1, 0);
        check_eq("lat_two_clk", ov_at_neg, 1'b1);

        // Drain whatever remains
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check_eq("final_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
